// File: rtl/word_block_packer.sv
// Packs a 32-bit word stream into WORDS-wide blocks and queues them in a
// 2-entry FIFO toward a valid/ready consumer; dropped blocks set a sticky flag.
module word_block_packer #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned CW    = $clog2(WORDS) + 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [31:0]         InData,
  input  logic                InValid,
  input  logic                Flush,
  output logic [32*WORDS-1:0] OutData,
  output logic [CW-1:0]       OutCount,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                Overflow
);

  localparam int unsigned BW = 32 * WORDS;

  logic [BW-1:0] asm_q, asm_d, asm_ins;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [BW-1:0] q0_data_q, q0_data_d, q1_data_q, q1_data_d;
  logic [CW-1:0] q0_cnt_q, q0_cnt_d, q1_cnt_q, q1_cnt_d;
  logic          q0_vld_q, q0_vld_d, q1_vld_q, q1_vld_d;
  logic          ovf_q, ovf_d;
  logic          full_push, flush_push, push, pop;
  logic [CW-1:0] push_cnt;

  // Entry 0 is the head and is held at zero when empty, so outputs come straight from flops.
  assign OutData  = q0_data_q;
  assign OutCount = q0_cnt_q;
  assign OutValid = q0_vld_q;
  assign Overflow = ovf_q;

  always_comb begin
    asm_ins = asm_q;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (InValid && (cnt_q == CW'(i))) asm_ins[32*i +: 32] = InData;
    end
    cnt_inc    = cnt_q + CW'(InValid);
    full_push  = InValid && (cnt_q == CW'(WORDS - 1));
    // A flush on the completing word rides on the full push rather than adding a second one.
    flush_push = Flush && !full_push && (cnt_inc != '0);
    push       = full_push || flush_push;
    push_cnt   = full_push ? CW'(WORDS) : cnt_inc;
    pop        = q0_vld_q && OutReady;

    // Assembly register is cleared after every push so unfilled slots read as zero padding.
    asm_d = push ? '0 : asm_ins;
    cnt_d = push ? '0 : cnt_inc;

    q0_data_d = q0_data_q;
    q0_cnt_d  = q0_cnt_q;
    q0_vld_d  = q0_vld_q;
    q1_data_d = q1_data_q;
    q1_cnt_d  = q1_cnt_q;
    q1_vld_d  = q1_vld_q;
    ovf_d     = ovf_q;

    if (pop) begin
      q0_data_d = q1_data_q;
      q0_cnt_d  = q1_cnt_q;
      q0_vld_d  = q1_vld_q;
      q1_data_d = '0;
      q1_cnt_d  = '0;
      q1_vld_d  = 1'b0;
    end

    // Push lands in the first free slot after any same-cycle pop.
    if (push) begin
      if (!q0_vld_d) begin
        q0_data_d = asm_ins;
        q0_cnt_d  = push_cnt;
        q0_vld_d  = 1'b1;
      end else if (!q1_vld_d) begin
        q1_data_d = asm_ins;
        q1_cnt_d  = push_cnt;
        q1_vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      asm_q     <= '0;
      cnt_q     <= '0;
      q0_data_q <= '0;
      q0_cnt_q  <= '0;
      q0_vld_q  <= 1'b0;
      q1_data_q <= '0;
      q1_cnt_q  <= '0;
      q1_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      q0_data_q <= q0_data_d;
      q0_cnt_q  <= q0_cnt_d;
      q0_vld_q  <= q0_vld_d;
      q1_data_q <= q1_data_d;
      q1_cnt_q  <= q1_cnt_d;
      q1_vld_q  <= q1_vld_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
